// File: rtl/stream_io_ctrl.sv
// stream_io_ctrl: host command engine moving words to/from stream memories and running execution
module stream_io_ctrl #(
  parameter int N_PE = 64,
  parameter int ADDR_L = 10,
  parameter int DATA_L = 32,
  parameter int RD_TIMEOUT = 16,
  localparam int STREAM_ID_L = $clog2(N_PE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    cmd_op,
  input  logic [1:0]                    cmd_type,
  input  logic [STREAM_ID_L-1:0]        cmd_stream,
  input  logic [ADDR_L-1:0]             cmd_addr,
  input  logic [ADDR_L:0]               cmd_len,
  input  logic                          cmd_vld,
  output logic                          cmd_rdy,
  input  logic [DATA_L-1:0]             host_wr_data,
  input  logic                          host_wr_vld,
  output logic                          host_wr_rdy,
  output logic [DATA_L-1:0]             host_rd_data,
  output logic                          host_rd_vld,
  input  logic                          host_rd_rdy,
  output logic                          busy,
  output logic                          err,
  output logic [DATA_L-1:0]             wr_data_io,
  output logic [2+STREAM_ID_L+ADDR_L-1:0] full_addr_io,
  output logic                          wr_vld_io,
  output logic                          rd_vld_io,
  input  logic [DATA_L-1:0]             rd_data_io,
  input  logic                          rd_data_vld_io,
  output logic                          reset_execution_io,
  output logic                          enable_execution_io,
  input  logic                          done_execution_io
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RD_OUT, EX_RST, EX_RUN} state_t;
  state_t state, nxt;
  logic [1:0] typ;
  logic [STREAM_ID_L-1:0] strm;
  logic [ADDR_L-1:0] cur_addr;
  logic [ADDR_L:0] len, cnt;
  logic [TW-1:0] tmr;
  logic acc, bad_t, bad, wr_hs, rd_hs, last, tmo;
  logic [2+STREAM_ID_L+ADDR_L-1:0] rd_fa;
  assign acc = cmd_vld && state == IDLE;
  assign bad_t = cmd_op == 2'd3 || (!cmd_op[1] && cmd_type == 2'd3);
  assign bad = bad_t || cmd_len == '0;
  assign wr_hs = state == WR && host_wr_vld;
  assign rd_hs = state == RD_OUT && host_rd_rdy;
  assign last = cnt == len - 1'b1;
  assign tmo = tmr == TW'(RD_TIMEOUT - 1);
  assign rd_fa = state == IDLE ? {cmd_type, cmd_stream, cmd_addr} : {typ, strm, cur_addr + 1'b1};
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // next-state selection
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (acc && !bad) nxt = cmd_op == 2'd0 ? WR : cmd_op == 2'd1 ? RD_REQ : EX_RST;
      WR:      if (host_wr_vld && last) nxt = IDLE;
      RD_REQ:  nxt = RD_WAIT;
      RD_WAIT: nxt = rd_data_vld_io ? RD_OUT : tmo ? IDLE : RD_WAIT;
      RD_OUT:  if (host_rd_rdy) nxt = last ? IDLE : RD_REQ;
      EX_RST:  nxt = EX_RUN;
      EX_RUN:  if (done_execution_io) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // host-side handshake outputs decoded from state
  always_comb begin
    cmd_rdy = state == IDLE;
    host_wr_rdy = state == WR;
    busy = state != IDLE;
  end
  // strobes follow the next state so each is high exactly while its state is current
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_io <= 1'b0;
      rd_vld_io <= 1'b0;
      reset_execution_io <= 1'b0;
      enable_execution_io <= 1'b0;
      wr_data_io <= '0;
      full_addr_io <= '0;
      host_rd_data <= '0;
      host_rd_vld <= 1'b0;
      err <= 1'b0;
      typ <= '0;
      strm <= '0;
      cur_addr <= '0;
      len <= '0;
      cnt <= '0;
      tmr <= '0;
    end else begin
      wr_vld_io <= wr_hs;
      rd_vld_io <= nxt == RD_REQ;
      reset_execution_io <= nxt == EX_RST;
      enable_execution_io <= nxt == EX_RUN;
      tmr <= state == RD_WAIT ? tmr + 1'b1 : '0;
      if (acc) begin
        typ <= cmd_type;
        strm <= cmd_stream;
        cur_addr <= cmd_addr;
        len <= cmd_len;
        cnt <= '0;
      end
      if (acc && bad_t) err <= 1'b1;
      if (wr_hs) begin
        wr_data_io <= host_wr_data;
        full_addr_io <= {typ, strm, cur_addr};
        cur_addr <= cur_addr + 1'b1;
        cnt <= cnt + 1'b1;
      end
      if (nxt == RD_REQ) full_addr_io <= rd_fa;
      if (state == RD_WAIT && rd_data_vld_io) begin
        host_rd_data <= rd_data_io;
        host_rd_vld <= 1'b1;
      end
      if (state == RD_WAIT && !rd_data_vld_io && tmo) err <= 1'b1;
      if (rd_hs) begin
        host_rd_vld <= 1'b0;
        cur_addr <= cur_addr + 1'b1;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/stream_io_ctrl.md
STREAM_IO_CTRL -- requirements
Module: stream_io_ctrl

Interface
REQ-001 The module SHALL have parameter N_PE, default 64, meaning number of streams per type (STREAM_ID_L = clog2(N_PE)).
REQ-002 The module SHALL have parameter ADDR_L, default 10, meaning per-stream word address width.
REQ-003 The module SHALL have parameter DATA_L, default 32, meaning IO data width.
REQ-004 The module SHALL have parameter RD_TIMEOUT, default 16, meaning maximum cycles to wait for read data.
REQ-005 The module SHALL have these ports, with clock and reset first:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_op  in  2  0=WRITE, 1=READ, 2=RUN, 3=reserved.
- cmd_type  in  2  0=instr, 1=ld, 2=st, 3=invalid.
- cmd_stream  in  STREAM_ID_L  target stream.
- cmd_addr  in  ADDR_L  start word address.
- cmd_len  in  ADDR_L+1  word count.
- cmd_vld / cmd_rdy  in/out  1  command handshake.
- host_wr_data  in  DATA_L  write payload.
- host_wr_vld / host_wr_rdy  in/out  1  payload handshake.
- host_rd_data  out  DATA_L  readback word.
- host_rd_vld / host_rd_rdy  out/in  1  readback handshake.
- busy  out  1  state != IDLE.
- err  out  1  sticky error flag.
- wr_data_io  out  DATA_L  write data to stream memories.
- full_addr_io  out  2+STREAM_ID_L+ADDR_L  {type, stream, addr}.
- wr_vld_io, rd_vld_io  out  1  single-cycle IO strobes.
- rd_data_io  in  DATA_L  read data.
- rd_data_vld_io  in  1  read data valid.
- reset_execution_io, enable_execution_io  out  1  execution control.
- done_execution_io  in  1  execution finished.

Function
REQ-006 The FSM SHALL have states IDLE, WR, RD_REQ, RD_WAIT, RD_OUT, EX_RST, EX_RUN; cmd_rdy SHALL be 1 only in IDLE.
REQ-007 On a cmd handshake the block SHALL latch type, stream, addr and len, clear the word counter, and move to WR, RD_REQ or EX_RST per cmd_op in the next cycle.
REQ-008 A command with cmd_len==0, op 3, or (op WRITE/READ with cmd_type 3) SHALL be consumed with no IO strobe and SHALL stay in IDLE; op 3 and type 3 SHALL set err.
REQ-009 In WR, host_wr_rdy SHALL be 1; each host_wr handshake at cycle t SHALL produce wr_vld_io=1 at t+1 with wr_data_io = payload and full_addr_io = {type, stream, cur_addr}.
REQ-010 cur_addr SHALL increment by 1 after each word, modulo 2^ADDR_L; type and stream SHALL never change within a command.
REQ-011 After handshake of word len-1, the FSM SHALL return to IDLE; the final wr_vld_io pulse SHALL still issue at t+1.
REQ-012 In RD_REQ the block SHALL drive rd_vld_io=1 for exactly one cycle with full_addr_io = current address, then enter RD_WAIT; at most one read SHALL be outstanding.
REQ-013 In RD_WAIT, rd_data_vld_io=1 SHALL capture rd_data_io into host_rd_data, set host_rd_vld next cycle, and enter RD_OUT.
REQ-014 If RD_TIMEOUT cycles elapse in RD_WAIT without rd_data_vld_io, the block SHALL set err, abandon the command and return to IDLE.
REQ-015 In RD_OUT, host_rd_data and host_rd_vld SHALL hold stable until host_rd_rdy; on handshake the FSM SHALL go to RD_REQ, or to IDLE if the last word.
REQ-016 rd_data_vld_io outside RD_WAIT SHALL be ignored.
REQ-017 EX_RST SHALL drive reset_execution_io=1 for exactly one cycle, then enter EX_RUN.
REQ-018 EX_RUN SHALL hold enable_execution_io=1 until done_execution_io is sampled 1; in that cycle the FSM SHALL go to IDLE and deassert enable the next cycle.
REQ-019 wr_vld_io, rd_vld_io and reset_execution_io SHALL never be asserted in the same cycle.
REQ-020 All IO-side outputs SHALL be registered.

Reset
REQ-021 On rst, the state SHALL become IDLE, and every output SHALL be 0 on the next cycle except cmd_rdy, which SHALL be 1.
REQ-022 A rst mid-command SHALL abort the command with no further IO strobes; err SHALL be cleared only by rst.

Verification
REQ-023 WRITE type=1, stream=5, addr=0x3FE, len=3, payload A,B,C -> three wr_vld_io pulses at addrs 0x3FE, 0x3FF, 0x000 with stream 5 and type 1.
REQ-024 READ len=2 with 3-cycle data latency and host_rd_rdy held low for 4 cycles -> one rd_vld_io per word; host_rd_data stays stable while stalled.
REQ-025 READ with rd_data_vld_io never asserted -> err=1 after 16 cycles; busy=0 and cmd_rdy=1 next cycle.
REQ-026 RUN with done_execution_io asserted 10 cycles later -> one reset_execution_io pulse, then enable_execution_io high for 10 cycles, then 0.
REQ-027 cmd_len=0 and cmd_type=3 commands -> no IO strobes; err=1 only after the type=3 command.
REQ-028 rst asserted during WR after 1 of 4 words -> no further wr_vld_io, all outputs 0, cmd_rdy=1.
